// File: rtl/adc_sample_capture.sv
// -----------------------------------------------------------------------------
// adc_sample_capture
//
// Runs one serial read of an external 12-bit ADC for every sample-rate tick.
// A frame is chip-select low, WORD_LENGTH SCLK periods (low half then high
// half, CLOCK_DIVIDE clocks each), then chip-select high. The last
// SAMPLE_BITS bits of the frame are pushed into a small FIFO and offered
// downstream on a valid/ready handshake.
//
// The tick is registered once before the FSM sees it. Chip select, SCLK,
// busy, valid and sample are registered from next-state values, so each one
// changes on the same edge as the state it reflects. With tick_i sampled at
// edge k, chip select falls at k+1, STORE is entered at k+34D+1 and valid_o
// rises at k+34D+2.
//
// Ports:
//   clock_i      in   system clock, rising edge
//   reset_ni     in   asynchronous active-low reset
//   enable_i     in   block enable; low aborts the frame, flushes the FIFO
//                     and clears overrun on the next edge
//   tick_i       in   one-cycle sample request
//   adc_sdata_i  in   ADC serial data, MSB first
//   adc_cs_no    out  ADC chip select, active low
//   adc_sclk_o   out  ADC serial clock, idles high
//   sample_o     out  FIFO head sample
//   valid_o      out  FIFO not empty
//   ready_i      in   downstream takes sample_o this cycle
//   busy_o       out  FSM not idle
//   overrun_o    out  sticky: tick while busy, or sample dropped on full FIFO
//
// FIFO_DEPTH must be a power of two and at least 2.
// -----------------------------------------------------------------------------
module adc_sample_capture #(
  parameter int WORD_LENGTH  = 16,
  parameter int SAMPLE_BITS  = 12,
  parameter int CLOCK_DIVIDE = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                   clock_i,
  input  logic                   reset_ni,
  input  logic                   enable_i,
  input  logic                   tick_i,
  input  logic                   adc_sdata_i,
  output logic                   adc_cs_no,
  output logic                   adc_sclk_o,
  output logic [SAMPLE_BITS-1:0] sample_o,
  output logic                   valid_o,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   overrun_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int DIV_W = $clog2(2 * CLOCK_DIVIDE + 1);
  localparam int BIT_W = $clog2(WORD_LENGTH + 1);

  localparam logic [DIV_W-1:0] HALF_LAST   = DIV_W'(CLOCK_DIVIDE - 1);
  localparam logic [DIV_W-1:0] HALF        = DIV_W'(CLOCK_DIVIDE);
  localparam logic [DIV_W-1:0] PERIOD_LAST = DIV_W'(2 * CLOCK_DIVIDE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WORD_LENGTH - 1);
  localparam logic [CNT_W-1:0] FULL_COUNT  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SELECT   = 3'd1,
    ST_SHIFT    = 3'd2,
    ST_DESELECT = 3'd3,
    ST_STORE    = 3'd4
  } state_t;

  state_t                 state_q, state_d;
  logic                   tick_q, tick_d;
  logic [DIV_W-1:0]       div_q, div_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic [WORD_LENGTH-1:0] shift_q, shift_d;
  logic                   cs_q, cs_d;
  logic                   sclk_q, sclk_d;
  logic                   busy_q, busy_d;
  logic                   overrun_q, overrun_d;
  logic                   valid_q, valid_d;
  logic [SAMPLE_BITS-1:0] sample_q, sample_d;
  logic [SAMPLE_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_BITS-1:0] mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]       count_q, count_d;

  logic push_req_s;
  logic push_s;
  logic pop_s;
  logic full_s;

  // The leading frame bits are shifted out of the top and never looked at.
  logic unused_s;
  assign unused_s = shift_q[WORD_LENGTH-1];

  // Register the request; a disabled block never sees a tick.
  always_comb begin
    tick_d = tick_i & enable_i;
  end

  // Frame sequencer: next state, half-period / bit counters and shift register.
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
      div_d   = '0;
      bit_d   = '0;
      shift_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (tick_q) begin
            state_d = ST_SELECT;
            div_d   = '0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_SELECT: begin
          if (div_q == HALF_LAST) begin
            state_d = ST_SHIFT;
            div_d   = '0;
            bit_d   = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_SHIFT: begin
          // This is the edge on which the registered SCLK goes 0->1.
          if (div_q == HALF_LAST) begin
            shift_d = {shift_q[WORD_LENGTH-2:0], adc_sdata_i};
          end else begin
            shift_d = shift_q;
          end
          if (div_q == PERIOD_LAST) begin
            div_d = '0;
            if (bit_q == BIT_LAST) begin
              state_d = ST_DESELECT;
            end else begin
              bit_d = bit_q + BIT_W'(1);
            end
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_DESELECT: begin
          if (div_q == HALF_LAST) begin
            state_d = ST_STORE;
            div_d   = '0;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
        end
        ST_STORE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // Pin decode from the next state so the pins move with the state register.
  always_comb begin
    cs_d   = 1'b1;
    sclk_d = 1'b1;
    busy_d = (state_d != ST_IDLE);
    case (state_d)
      ST_SELECT, ST_DESELECT: begin
        cs_d = 1'b0;
      end
      ST_SHIFT: begin
        cs_d   = 1'b0;
        sclk_d = (div_d >= HALF);
      end
      default: begin
        cs_d   = 1'b1;
        sclk_d = 1'b1;
      end
    endcase
  end

  assign push_req_s = (state_q == ST_STORE);
  assign pop_s      = valid_q & ready_i;
  assign full_s     = (count_q == FULL_COUNT);
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign push_s     = push_req_s & (~full_s | pop_s);

  // Sample FIFO, overrun flag and the registered head/valid outputs.
  always_comb begin
    mem_d     = mem_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (!enable_i) begin
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      overrun_d = 1'b0;
    end else begin
      if (push_s) begin
        mem_d[wr_ptr_q] = shift_q[SAMPLE_BITS-1:0];
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({push_s, pop_s})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if ((push_req_s & ~push_s) | (tick_q & (state_q != ST_IDLE))) begin
        overrun_d = 1'b1;
      end else begin
        overrun_d = overrun_q;
      end
    end
    valid_d = (count_d != '0);
    if (valid_d) begin
      sample_d = mem_d[rd_ptr_d];
    end else begin
      sample_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= ST_IDLE;
      tick_q    <= 1'b0;
      div_q     <= '0;
      bit_q     <= '0;
      shift_q   <= '0;
      cs_q      <= 1'b1;
      sclk_q    <= 1'b1;
      busy_q    <= 1'b0;
      overrun_q <= 1'b0;
      valid_q   <= 1'b0;
      sample_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      cs_q      <= cs_d;
      sclk_q    <= sclk_d;
      busy_q    <= busy_d;
      overrun_q <= overrun_d;
      valid_q   <= valid_d;
      sample_q  <= sample_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
    end
  end

  assign adc_cs_no  = cs_q;
  assign adc_sclk_o = sclk_q;
  assign busy_o     = busy_q;
  assign overrun_o  = overrun_q;
  assign valid_o    = valid_q;
  assign sample_o   = sample_q;

endmodule

// File: tb/tb_adc_sample_capture.sv
// -----------------------------------------------------------------------------
// tb_adc_sample_capture
//
// Directed bench for adc_sample_capture with default parameters (D = 4).
// A behavioural ADC drives adc_sdata_i MSB first, presenting the next bit
// after every SCLK falling edge while chip select is low.
// -----------------------------------------------------------------------------
module tb_adc_sample_capture;

  localparam int D = 4;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b0;
  logic        enable_i = 1'b0;
  logic        tick_i = 1'b0;
  logic        adc_sdata_i = 1'b0;
  logic        ready_i = 1'b0;
  logic        adc_cs_no;
  logic        adc_sclk_o;
  logic [11:0] sample_o;
  logic        valid_o;
  logic        busy_o;
  logic        overrun_o;

  int checks = 0;
  int failures = 0;

  adc_sample_capture dut (
    .clock_i     (clock_i),
    .reset_ni    (reset_ni),
    .enable_i    (enable_i),
    .tick_i      (tick_i),
    .adc_sdata_i (adc_sdata_i),
    .adc_cs_no   (adc_cs_no),
    .adc_sclk_o  (adc_sclk_o),
    .sample_o    (sample_o),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .busy_o      (busy_o),
    .overrun_o   (overrun_o)
  );

  always #5 clock_i = ~clock_i;

  // Behavioural ADC: word presented MSB first, one bit per SCLK falling edge.
  logic [15:0] adc_word = 16'h0000;
  int          adc_idx = 15;

  always @(negedge adc_cs_no) adc_idx = 15;

  always @(negedge adc_sclk_o) begin
    if (!adc_cs_no && adc_idx >= 0) begin
      adc_sdata_i = adc_word[adc_idx];
      adc_idx     = adc_idx - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, leaving the caller 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock_i);
      #1;
    end
  endtask

  // Tick sampled on the next rising edge (edge k); returns just after edge k.
  task automatic pulse_tick();
    tick_i = 1'b1;
    step(1);
    tick_i = 1'b0;
  endtask

  // Watch 150 cycles after a tick; indices are edges after the tick edge.
  task automatic observe_frame(output int cs_first, output int cs_low, output int sclk_first,
                               output int pulses, output int valid_first);
    logic prev_sclk;
    cs_first = 0; cs_low = 0; sclk_first = 0; pulses = 0; valid_first = 0;
    prev_sclk = adc_sclk_o;
    for (int i = 1; i <= 150; i++) begin
      step(1);
      if (!adc_cs_no) begin
        cs_low++;
        if (cs_first == 0) cs_first = i;
      end
      if (!adc_sclk_o && sclk_first == 0) sclk_first = i;
      if (adc_sclk_o && !prev_sclk && !adc_cs_no) pulses++;
      if (valid_o && valid_first == 0) valid_first = i;
      prev_sclk = adc_sclk_o;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int cs_first, cs_low, sclk_first, pulses, valid_first;
    logic seen;

    // ---- reset values ----
    step(2);
    check("rst_cs", adc_cs_no, 1);
    check("rst_sclk", adc_sclk_o, 1);
    check("rst_valid", valid_o, 0);
    check("rst_sample", sample_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_overrun", overrun_o, 0);
    reset_ni = 1'b1;
    step(1);
    enable_i = 1'b1;
    step(2);

    // ---- single frame 0x0ABC ----
    adc_word = 16'h0ABC;
    pulse_tick();
    observe_frame(cs_first, cs_low, sclk_first, pulses, valid_first);
    check("f1_cs_fall", cs_first, 1);
    check("f1_cs_low_len", cs_low, 34 * D);
    check("f1_sclk_first_fall", sclk_first, D + 1);
    check("f1_sclk_pulses", pulses, 16);
    check("f1_valid_rise", valid_first, 138);
    check("f1_sample", sample_o, 12'hABC);
    check("f1_overrun", overrun_o, 0);
    ready_i = 1'b1;
    step(1);
    ready_i = 1'b0;
    check("f1_pop_valid", valid_o, 0);

    // ---- five ticks, 140 apart, no reads: fifth dropped ----
    for (int j = 1; j <= 5; j++) begin
      adc_word = 16'(j);
      pulse_tick();
      step(139);
      if (j == 4) begin
        check("ovf_no_overrun_at_4", overrun_o, 0);
      end
    end
    check("ovf_overrun", overrun_o, 1);
    ready_i = 1'b1;
    for (int j = 1; j <= 4; j++) begin
      check("ovf_drain_valid", valid_o, 1);
      check("ovf_drain_sample", sample_o, j);
      step(1);
    end
    ready_i = 1'b0;
    check("ovf_drain_empty", valid_o, 0);
    enable_i = 1'b0;
    step(1);
    check("dis_clears_overrun", overrun_o, 0);
    enable_i = 1'b1;
    step(1);

    // ---- second tick 50 cycles after the first ----
    adc_word = 16'h0123;
    pulse_tick();
    step(49);
    pulse_tick();
    step(1);
    check("early_tick_overrun", overrun_o, 1);
    check("early_tick_busy", busy_o, 1);
    step(87);
    check("early_tick_valid", valid_o, 1);
    check("early_tick_sample", sample_o, 12'h123);
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (!adc_cs_no || busy_o) seen = 1'b1;
      step(1);
    end
    check("early_tick_no_second_frame", seen, 0);
    ready_i = 1'b1;
    step(1);
    ready_i = 1'b0;
    check("early_tick_single_sample", valid_o, 0);
    enable_i = 1'b0;
    step(1);
    enable_i = 1'b1;
    step(1);

    // ---- full FIFO with a pop in the STORE cycle ----
    for (int j = 1; j <= 4; j++) begin
      adc_word = 16'h00A0 + 16'(j);
      pulse_tick();
      step(139);
    end
    adc_word = 16'h00A5;
    pulse_tick();
    step(137);
    ready_i = 1'b1;
    step(1);
    ready_i = 1'b0;
    check("full_pop_overrun", overrun_o, 0);
    check("full_pop_valid", valid_o, 1);
    ready_i = 1'b1;
    for (int j = 2; j <= 5; j++) begin
      check("full_pop_order", sample_o, 12'h0A0 + 12'(j));
      step(1);
    end
    ready_i = 1'b0;
    check("full_pop_empty", valid_o, 0);

    // ---- enable dropped during bit 7 of SHIFT ----
    adc_word = 16'h0777;
    pulse_tick();
    step(139);
    check("abort_pre_valid", valid_o, 1);
    adc_word = 16'h0555;
    pulse_tick();
    step(19);
    pulse_tick();
    step(43);
    check("abort_pre_cs", adc_cs_no, 0);
    check("abort_pre_overrun", overrun_o, 1);
    enable_i = 1'b0;
    step(1);
    check("abort_cs", adc_cs_no, 1);
    check("abort_sclk", adc_sclk_o, 1);
    check("abort_busy", busy_o, 0);
    check("abort_valid", valid_o, 0);
    check("abort_overrun", overrun_o, 0);
    pulse_tick();
    step(2);
    check("disabled_tick_ignored", busy_o, 0);
    enable_i = 1'b1;
    step(1);
    adc_word = 16'h0DEF;
    pulse_tick();
    observe_frame(cs_first, cs_low, sclk_first, pulses, valid_first);
    check("reen_cs_low_len", cs_low, 34 * D);
    check("reen_sclk_pulses", pulses, 16);
    check("reen_valid_rise", valid_first, 138);
    check("reen_sample", sample_o, 12'hDEF);

    // ---- asynchronous reset mid-SELECT ----
    pulse_tick();
    step(2);
    check("arst_pre_cs", adc_cs_no, 0);
    #3;
    reset_ni = 1'b0;
    #1;
    check("arst_cs", adc_cs_no, 1);
    check("arst_sclk", adc_sclk_o, 1);
    check("arst_busy", busy_o, 0);
    check("arst_valid", valid_o, 0);
    check("arst_sample", sample_o, 0);
    check("arst_overrun", overrun_o, 0);
    step(2);
    reset_ni = 1'b1;
    step(3);
    check("arst_frame_discarded", busy_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
